rq_mod_round_unit: RTL



---
 rtl/rq_mod_round_unit_if.sv | 29 ++
 rtl/rq_mod_round_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rq_mod_round_unit_if.sv
// Streaming handshake bundle between the polynomial multiplier, the mod/round unit
// and the encapsulation datapath.
interface rq_mod_round_unit_if #(
  parameter int IW = 26,
  parameter int OW = 13,
  parameter int AW = 11
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] modulo_out;
  logic signed [OW-1:0] round_out;
  logic [AW-1:0]        out_index;
  logic                 out_last;
  logic                 done;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, modulo_out, round_out, out_index, out_last, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, modulo_out, round_out, out_index, out_last, done
  );
endinterface

// File: rtl/rq_mod_round_unit.sv
// Three-stage streaming reduction of signed accumulator coefficients to centered
// residues mod Q, plus the nearest multiple of 3, with per-polynomial indexing.
module rq_mod_round_unit #(
  parameter int P  = 761,
  parameter int Q  = 4591,
  parameter int IW = 26,
  parameter int OW = 13,
  parameter int AW = 11
) (
  input logic               clk,
  input logic               rst_n,
  rq_mod_round_unit_if.slave bus
);

  localparam int     QW    = $clog2(Q);
  localparam int     HALF  = (Q - 1) / 2;
  localparam longint BM    = (longint'(1) << IW) / longint'(Q);
  localparam longint OFS   = (longint'(1) << (IW - 1)) % longint'(Q);
  localparam int     MW    = $clog2(BM + 1);
  localparam int     PW    = IW + MW;
  localparam int     WW    = OW + 3;
  localparam int     THIRD = 21846;
  localparam logic [MW-1:0] BM_C     = MW'(BM);
  localparam logic [AW-1:0] LAST_IDX = AW'(P - 1);

  logic stall;
  logic accept;
  logic out_xfer;
  logic at_last;

  logic                 s1_valid;
  logic [IW-1:0]        s1_u;
  logic                 s2_valid;
  logic [QW-1:0]        s2_res;
  logic                 s3_valid;
  logic signed [OW-1:0] s3_mod;
  logic signed [OW-1:0] s3_rnd;
  logic [AW-1:0]        idx;
  logic                 done_q;

  logic [PW-1:0]        bar_prod;
  logic [MW-1:0]        bar_q;
  logic [IW-1:0]        bar_r0;
  logic [IW-1:0]        bar_r1;
  logic [IW-1:0]        bar_res;
  logic [QW-1:0]        res_c;

  logic signed [WW-1:0] ctr;
  logic [WW-1:0]        tsum;
  logic [WW+15:0]       tmul;
  logic [WW-1:0]        q3;
  logic [WW-1:0]        m3;
  logic signed [WW-1:0] rnd_w;

  assign stall    = s3_valid && !bus.out_ready;
  assign accept   = bus.in_valid && !stall;
  assign out_xfer = s3_valid && bus.out_ready;
  assign at_last  = s3_valid && (idx == LAST_IDX);

  assign bus.in_ready   = !stall;
  assign bus.out_valid  = s3_valid;
  assign bus.modulo_out = s3_mod;
  assign bus.round_out  = s3_rnd;
  assign bus.out_index  = idx;
  assign bus.out_last   = at_last;
  assign bus.done       = done_q;

  // S1 holds in_data + 2^(IW-1) (MSB flipped) so Barrett only ever sees unsigned
  // values; the offset is taken back out as OFS = 2^(IW-1) mod Q after reduction.
  always_comb begin
    bar_prod = PW'(s1_u) * PW'(BM_C);
    bar_q    = MW'(bar_prod >> IW);
    bar_r0   = s1_u - IW'(bar_q) * IW'(Q);
    bar_r1   = (bar_r0 >= IW'(Q)) ? bar_r0 - IW'(Q) : bar_r0;
    bar_res  = (bar_r1 >= IW'(OFS)) ? bar_r1 - IW'(OFS) : bar_r1 + IW'(Q - OFS);
    res_c    = QW'(bar_res);
  end

  // tsum = centered + (HALF+1) lies in [1, Q] and has the same residue mod 3 as
  // centered + 1; THIRD = ceil(2^16/3) divides exactly for operands below 2^15.
  always_comb begin
    ctr   = (s2_res > QW'(HALF)) ? WW'(s2_res) - WW'(Q) : WW'(s2_res);
    tsum  = WW'(ctr) + WW'(HALF + 1);
    tmul  = (WW + 16)'(tsum) * (WW + 16)'(THIRD);
    q3    = WW'(tmul >> 16);
    m3    = tsum - WW'(3) * q3;
    rnd_w = ctr - $signed(m3) + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (bus.start) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Data registers only load behind a valid token, so outputs stay put when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_u   <= '0;
      s2_res <= '0;
      s3_mod <= '0;
      s3_rnd <= '0;
    end else if (!stall && !bus.start) begin
      if (accept) begin
        s1_u <= {~bus.in_data[IW-1], bus.in_data[IW-2:0]};
      end
      if (s1_valid) begin
        s2_res <= res_c;
      end
      if (s2_valid) begin
        s3_mod <= OW'(ctr);
        s3_rnd <= OW'(rnd_w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      done_q <= 1'b0;
    end else if (bus.start) begin
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= out_xfer && at_last;
      if (out_xfer) begin
        idx <= at_last ? '0 : idx + AW'(1);
      end
    end
  end

endmodule
